// File: rtl/reconfig_responder.sv
// reconfig_responder: stand-in configuration controller answering an internal-reconfiguration initiator.
module reconfig_responder #(
  parameter int unsigned LOAD_CYCLES = 64,
  parameter logic [3:0]  VALID_MASK  = 4'b0101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cfg_CBSEL,
  input  logic       cfg_ENA,
  input  logic       cfg_CONFIG,
  output logic       cfg_ERROR,
  output logic       busy,
  output logic       load_done,
  output logic [1:0] active_image,
  output logic [7:0] load_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
  localparam logic [15:0] LAST = 16'(LOAD_CYCLES - 1);
  state_t state_q, state_d;
  logic config_q, req_q, req_d;
  logic [1:0] sel_q, sel_d, active_q, active_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] count_q, count_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      config_q <= 1'b0;
      req_q    <= 1'b0;
      sel_q    <= 2'd0;
      active_q <= 2'd0;
      cnt_q    <= 16'd0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      config_q <= cfg_CONFIG;
      req_q    <= req_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_q) state_d = VALID_MASK[cfg_CBSEL] ? LOAD : ERR;
      LOAD: state_d = !cfg_ENA ? ERR : (cnt_q == LAST) ? DONE : LOAD;
      DONE: state_d = IDLE;
      ERR:  state_d = cfg_ENA ? ERR : IDLE;
    endcase
  end
  // the edge is registered first; the FSM acts on it one cycle later
  always_comb begin
    req_d    = cfg_CONFIG & ~config_q & cfg_ENA;
    sel_d    = (state_q == IDLE && state_d == LOAD) ? cfg_CBSEL : sel_q;
    cnt_d    = (state_q == LOAD) ? cnt_q + 16'd1 : 16'd0;
    active_d = (state_d == DONE) ? sel_q : active_q;
    count_d  = (state_d == DONE && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
  end
  always_comb begin
    busy         = state_q == LOAD;
    load_done    = state_q == DONE;
    cfg_ERROR    = state_q == ERR;
    active_image = active_q;
    load_count   = count_q;
  end
endmodule

// File: tb/tb_reconfig_responder.sv
// tb_reconfig_responder: directed and randomized load requests checked against a transaction-level model.
module tb_reconfig_responder;
  localparam int L = 64;
  localparam logic [3:0] MASK = 4'b0101;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] cbsel, cbsel1, act, act1, m_act, sel_r;
  logic ena, cfg, ena1, cfg1, err, busy, done, err1, busy1, done1;
  logic [7:0] cnt, cnt1;
  int checks = 0, errors = 0, m_cnt = 0, m1 = 0, ab;
  always #5 clk = ~clk;
  reconfig_responder #(.LOAD_CYCLES(L), .VALID_MASK(MASK)) dut (
    .clk(clk), .rst(rst), .cfg_CBSEL(cbsel), .cfg_ENA(ena), .cfg_CONFIG(cfg),
    .cfg_ERROR(err), .busy(busy), .load_done(done), .active_image(act), .load_count(cnt));
  reconfig_responder #(.LOAD_CYCLES(1), .VALID_MASK(MASK)) dut1 (
    .clk(clk), .rst(rst), .cfg_CBSEL(cbsel1), .cfg_ENA(ena1), .cfg_CONFIG(cfg1),
    .cfg_ERROR(err1), .busy(busy1), .load_done(done1), .active_image(act1), .load_count(cnt1));
  function automatic logic [31:0] flags();
    return {29'd0, err, busy, done};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_chk(input string tag);
    chk({tag, "_active"}, 32'(act), 32'(m_act));
    chk({tag, "_count"}, 32'(cnt), 32'(m_cnt));
  endtask
  // one request: {err,busy,done} is checked every cycle; a valid load is busy for L cycles then pulses done
  task automatic run_load(input logic [1:0] sel, input int abort_at, input int hold);
    cbsel = sel; ena = 1'b1; cfg = 1'b1;
    @(negedge clk); chk("edge_cycle", flags(), 0);
    if (!MASK[sel]) begin
      repeat (3) begin @(negedge clk); chk("err_hold", flags(), 32'b100); end
      ena = 1'b0;
      @(negedge clk); chk("err_clear", flags(), 0);
    end else begin
      for (int i = 0; i < L; i++) begin
        @(negedge clk); chk("busy", flags(), 32'b010);
        if (i == abort_at) begin ena = 1'b0; break; end
      end
      @(negedge clk);
      if (abort_at >= 0 && abort_at < L) begin
        chk("abort_err", flags(), 32'b100);
        @(negedge clk); chk("abort_clear", flags(), 0);
      end else begin
        chk("done", flags(), 32'b001);
        m_act = sel;
        if (m_cnt < 255) m_cnt++;
        @(negedge clk); chk("done_single", flags(), 0);
      end
    end
    model_chk("after_load");
    repeat (hold) begin @(negedge clk); chk("no_retrigger", flags(), 0); end
    cfg = 1'b0; ena = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; cfg = 1'b0; ena = 1'b0; cbsel = 2'd0; cfg1 = 1'b0; ena1 = 1'b1; cbsel1 = 2'd0; m_act = 2'd0;
    repeat (2) @(negedge clk);
    chk("reset_flags", flags(), 0);
    model_chk("reset");
    rst = 1'b0;
    @(negedge clk);
    cfg = 1'b1;
    repeat (4) begin @(negedge clk); chk("ena_low_edge", flags(), 0); end
    model_chk("ena_low");
    cfg = 1'b0; ena = 1'b1;
    @(negedge clk);
    run_load(2'd2, -1, 200);
    run_load(2'd1, -1, 0);
    rst = 1'b1; @(negedge clk); rst = 1'b0; m_act = 2'd0; m_cnt = 0;
    @(negedge clk);
    run_load(2'd2, 30, 0);
    run_load(2'd2, -1, 0);
    cbsel = 2'd2; ena = 1'b1; cfg = 1'b1;
    repeat (11) @(negedge clk);
    chk("midload_busy", flags(), 32'b010);
    #2 rst = 1'b1; cfg = 1'b0;
    #1 m_act = 2'd0; m_cnt = 0;
    chk("async_reset_flags", flags(), 0);
    model_chk("async_reset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_load(2'd0, -1, 0);
    repeat (8) begin
      sel_r = 2'($urandom_range(3));
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(L - 1)) : -1;
      run_load(sel_r, ab, 0);
    end
    for (int i = 0; i < 257; i++) begin
      cfg1 = 1'b1;
      @(negedge clk);
      @(negedge clk); chk("sat_busy", 32'(busy1), 1);
      @(negedge clk); chk("sat_done", 32'(done1), 1);
      if (m1 < 255) m1++;
      chk("sat_count", 32'(cnt1), 32'(m1));
      cfg1 = 1'b0;
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
